// File: rtl/wb_trace_checker.sv
// Writeback trace checker: holds the core in reset, releases it, then compares
// each MEM/WB result against a preloaded expected table and reports the outcome.
module wb_trace_checker #(
    parameter int DATA_W       = 32,
    parameter int DEPTH        = 64,
    parameter int ADDR_W       = 6,
    parameter int RESET_CYCLES = 4,
    parameter int TIMEOUT      = 1024
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Start,
    input  logic              ExpWr,
    input  logic [ADDR_W-1:0] ExpAddr,
    input  logic [DATA_W-1:0] ExpData,
    input  logic [ADDR_W:0]   ExpLen,
    input  logic              WB_Valid,
    input  logic [DATA_W-1:0] WB_Data,
    output logic              CoreReset,
    output logic              Busy,
    output logic              Done,
    output logic              Pass,
    output logic              TimedOut,
    output logic [ADDR_W:0]   ErrCount,
    output logic [ADDR_W:0]   MatchCount,
    output logic [ADDR_W-1:0] FirstErrIdx,
    output logic [DATA_W-1:0] FirstErrData,
    output logic [31:0]       CycleCount
);

    localparam int              RC_W      = $clog2(RESET_CYCLES + 1);
    localparam logic [RC_W-1:0] RC_LAST   = RC_W'(RESET_CYCLES - 1);
    localparam logic [ADDR_W:0] DEPTH_L   = (ADDR_W + 1)'(DEPTH);
    localparam logic [31:0]     TIMEOUT_L = 32'(TIMEOUT);

    typedef enum logic [1:0] {S_IDLE, S_RST, S_RUN, S_DONE} state_t;

    state_t            state, state_nxt;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [RC_W-1:0]   rst_cnt;
    logic [ADDR_W:0]   len;
    logic [ADDR_W:0]   idx;
    logic [ADDR_W:0]   err_cnt;
    logic [ADDR_W:0]   match_cnt;
    logic [ADDR_W-1:0] first_idx;
    logic [DATA_W-1:0] first_data;
    logic [31:0]       cyc_cnt;
    logic              timed_out;

    logic              start_ok;
    logic              cmp_en;
    logic              cmp_eq;
    logic [DATA_W-1:0] exp_word;
    logic [ADDR_W:0]   idx_nxt;
    logic [31:0]       cyc_nxt;
    logic              fin_len;
    logic              fin_to;

    // Run-control decode shared by the FSM and the result registers.
    // idx stays below len <= DEPTH while comparing, so the low bits address the table.
    always_comb begin
        start_ok = Start && (state == S_IDLE || state == S_DONE);
        exp_word = mem[idx[ADDR_W-1:0]];
        cmp_en   = (state == S_RUN) && WB_Valid && (idx < len);
        cmp_eq   = (WB_Data == exp_word);
        idx_nxt  = idx + {{ADDR_W{1'b0}}, cmp_en};
        cyc_nxt  = (cyc_cnt == '1) ? cyc_cnt : cyc_cnt + 32'd1;
        // Reaching len wins over the timeout when both land in the same cycle.
        fin_len  = (idx_nxt == len);
        fin_to   = (cyc_nxt >= TIMEOUT_L) && !fin_len;
    end

    // State register.
    always_ff @(posedge Clk) begin
        if (Reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start_ok) state_nxt = S_RST;
            S_RST:   if (rst_cnt == RC_LAST) state_nxt = S_RUN;
            S_RUN:   if (fin_len || fin_to) state_nxt = S_DONE;
            S_DONE:  if (start_ok) state_nxt = S_RST;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Status outputs; the core is only released while running.
    always_comb begin
        CoreReset    = (state != S_RUN);
        Busy         = (state == S_RST) || (state == S_RUN);
        Done         = (state == S_DONE);
        Pass         = Done && (err_cnt == '0) && !timed_out;
        TimedOut     = Done && timed_out;
        ErrCount     = err_cnt;
        MatchCount   = match_cnt;
        FirstErrIdx  = first_idx;
        FirstErrData = first_data;
        CycleCount   = cyc_cnt;
    end

    // Expected table: written only while idle, never cleared by reset.
    always_ff @(posedge Clk) begin
        if (!Reset && ExpWr && state == S_IDLE) mem[ExpAddr] <= ExpData;
    end

    // Run counters and first-mismatch capture.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            rst_cnt    <= '0;
            len        <= '0;
            idx        <= '0;
            err_cnt    <= '0;
            match_cnt  <= '0;
            first_idx  <= '0;
            first_data <= '0;
            cyc_cnt    <= '0;
            timed_out  <= 1'b0;
        end else if (start_ok) begin
            rst_cnt    <= '0;
            len        <= (ExpLen > DEPTH_L) ? DEPTH_L : ExpLen;
            idx        <= '0;
            err_cnt    <= '0;
            match_cnt  <= '0;
            first_idx  <= '0;
            first_data <= '0;
            cyc_cnt    <= '0;
            timed_out  <= 1'b0;
        end else begin
            case (state)
                S_RST: rst_cnt <= rst_cnt + RC_W'(1);
                S_RUN: begin
                    cyc_cnt <= cyc_nxt;
                    idx     <= idx_nxt;
                    if (cmp_en) begin
                        if (cmp_eq) begin
                            match_cnt <= match_cnt + 1'b1;
                        end else begin
                            err_cnt <= err_cnt + 1'b1;
                            if (err_cnt == '0) begin
                                first_idx  <= idx[ADDR_W-1:0];
                                first_data <= WB_Data;
                            end
                        end
                    end
                    if (fin_to) timed_out <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_trace_checker.sv
// Directed bench for wb_trace_checker (DEPTH=8, RESET_CYCLES=4, TIMEOUT=16).
module tb_wb_trace_checker;

    localparam int DW = 32;
    localparam int DP = 8;
    localparam int AW = 3;

    logic          Clk = 1'b0;
    logic          Reset, Start, ExpWr, WB_Valid;
    logic [AW-1:0] ExpAddr;
    logic [DW-1:0] ExpData, WB_Data;
    logic [AW:0]   ExpLen;
    logic          CoreReset, Busy, Done, Pass, TimedOut;
    logic [AW:0]   ErrCount, MatchCount;
    logic [AW-1:0] FirstErrIdx;
    logic [DW-1:0] FirstErrData;
    logic [31:0]   CycleCount;

    int n_cmp = 0;
    int n_err = 0;

    wb_trace_checker #(.DATA_W(DW), .DEPTH(DP), .ADDR_W(AW), .RESET_CYCLES(4), .TIMEOUT(16)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .ExpWr(ExpWr), .ExpAddr(ExpAddr),
        .ExpData(ExpData), .ExpLen(ExpLen), .WB_Valid(WB_Valid), .WB_Data(WB_Data),
        .CoreReset(CoreReset), .Busy(Busy), .Done(Done), .Pass(Pass), .TimedOut(TimedOut),
        .ErrCount(ErrCount), .MatchCount(MatchCount), .FirstErrIdx(FirstErrIdx),
        .FirstErrData(FirstErrData), .CycleCount(CycleCount)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic [3:0]       len;
        logic [3:0]       n;
        logic [7:0][31:0] wb;
        logic             pass;
        logic             to;
        logic [3:0]       err;
        logic [3:0]       match;
        logic [2:0]       fidx;
        logic [31:0]      fdata;
        logic [31:0]      cyc;
    } vec_t;

    vec_t vecs [6];

    function automatic vec_t mk(int len, int n, logic [7:0][31:0] wb, int pass, int to,
                                int err, int match, int fidx, int fdata, int cyc);
        vec_t v;
        v.len = 4'(len); v.n = 4'(n); v.wb = wb; v.pass = 1'(pass); v.to = 1'(to);
        v.err = 4'(err); v.match = 4'(match); v.fidx = 3'(fidx);
        v.fdata = 32'(fdata); v.cyc = 32'(cyc);
        return v;
    endfunction

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic wait_run();
        int w = 0;
        while (CoreReset && w < 20) begin tick(); w++; end
        chk("run_reached", 32'(CoreReset), 32'd0);
    endtask

    task automatic wait_done();
        int w = 0;
        while (!Done && w < 40) begin tick(); w++; end
        chk("done_reached", 32'(Done), 32'd1);
    endtask

    // Pulses Start (ExpWr, if set by the caller, is dropped after the same edge),
    // counts CoreReset cycles, idles gap RUN cycles, then streams n writebacks.
    task automatic run(input logic [3:0] len, input int n, input logic [7:0][31:0] wb,
                       input int gap, output int rst_cyc);
        ExpLen = len; Start = 1'b1;
        tick();
        Start = 1'b0; ExpWr = 1'b0;
        chk("busy_after_start", 32'(Busy), 32'd1);
        chk("results_cleared", 32'(ErrCount) | 32'(MatchCount) | CycleCount | 32'(Done), 32'd0);
        rst_cyc = 0;
        while (CoreReset && rst_cyc < 20) begin rst_cyc++; tick(); end
        repeat (gap) tick();
        for (int i = 0; i < n; i++) begin
            WB_Valid = 1'b1; WB_Data = wb[i];
            tick();
        end
        WB_Valid = 1'b0;
        wait_done();
    endtask

    initial begin
        int rc;
        Reset = 1'b1; Start = 1'b0; ExpWr = 1'b0; ExpAddr = '0; ExpData = '0;
        ExpLen = '0; WB_Valid = 1'b0; WB_Data = '0;
        tick(); tick();
        chk("rst_corereset", 32'(CoreReset), 32'd1);
        chk("rst_busy_done", 32'({Busy, Done, Pass, TimedOut}), 32'd0);
        chk("rst_counts", 32'(ErrCount) | 32'(MatchCount) | CycleCount, 32'd0);
        chk("rst_firsterr", 32'(FirstErrIdx) | FirstErrData, 32'd0);
        Reset = 1'b0;
        tick();

        // Table = {1,2,...,8}
        for (int i = 0; i < DP; i++) begin
            ExpWr = 1'b1; ExpAddr = 3'(i); ExpData = 32'(i + 1);
            tick();
        end
        ExpWr = 1'b0;

        //          len n   wb (index 0 rightmost)                    pass to err mat fidx fdata cyc
        vecs[0] = mk(4, 4, {32'd0,32'd0,32'd0,32'd0,32'd4,32'd3,32'd2,32'd1}, 1, 0, 0, 4, 0, 0,  4);
        vecs[1] = mk(4, 4, {32'd0,32'd0,32'd0,32'd0,32'd7,32'd3,32'd9,32'd1}, 0, 0, 2, 2, 1, 9,  4);
        vecs[2] = mk(4, 2, {32'd0,32'd0,32'd0,32'd0,32'd0,32'd0,32'd2,32'd1}, 0, 1, 0, 2, 0, 0, 16);
        vecs[3] = mk(0, 0, {32'd0,32'd0,32'd0,32'd0,32'd0,32'd0,32'd0,32'd0}, 1, 0, 0, 0, 0, 0,  1);
        vecs[4] = mk(13,8, {32'd8,32'd7,32'd6,32'd5,32'd4,32'd3,32'd2,32'd1}, 1, 0, 0, 8, 0, 0,  8);
        vecs[5] = mk(2, 2, {32'd0,32'd0,32'd0,32'd0,32'd0,32'd0,32'd6,32'd5}, 0, 0, 2, 0, 0, 5,  2);

        for (int k = 0; k < 6; k++) begin
            run(vecs[k].len, int'(vecs[k].n), vecs[k].wb, 0, rc);
            chk($sformatf("v%0d_rstcyc", k), 32'(rc), 32'd4);
            chk($sformatf("v%0d_pass", k), 32'(Pass), 32'(vecs[k].pass));
            chk($sformatf("v%0d_timedout", k), 32'(TimedOut), 32'(vecs[k].to));
            chk($sformatf("v%0d_err", k), 32'(ErrCount), 32'(vecs[k].err));
            chk($sformatf("v%0d_match", k), 32'(MatchCount), 32'(vecs[k].match));
            chk($sformatf("v%0d_fidx", k), 32'(FirstErrIdx), 32'(vecs[k].fidx));
            chk($sformatf("v%0d_fdata", k), FirstErrData, vecs[k].fdata);
            chk($sformatf("v%0d_cycles", k), CycleCount, vecs[k].cyc);
            chk($sformatf("v%0d_corereset", k), 32'(CoreReset), 32'd1);
        end

        // Last compare lands on the timeout cycle: counted, not a timeout.
        run(4'd1, 1, {32'd0,32'd0,32'd0,32'd0,32'd0,32'd0,32'd0,32'd1}, 15, rc);
        chk("edge_to_pass", 32'(Pass), 32'd1);
        chk("edge_to_timedout", 32'(TimedOut), 32'd0);
        chk("edge_to_match", 32'(MatchCount), 32'd1);
        chk("edge_to_cycles", CycleCount, 32'd16);

        // Reset in RUN after two compares.
        ExpLen = 4'd4; Start = 1'b1; tick(); Start = 1'b0;
        wait_run();
        WB_Valid = 1'b1; WB_Data = 32'd1; tick();
        WB_Data = 32'd2; tick();
        WB_Valid = 1'b0;
        chk("midrun_match2", 32'(MatchCount), 32'd2);
        Reset = 1'b1; tick();
        chk("midrun_corereset", 32'(CoreReset), 32'd1);
        chk("midrun_busy", 32'(Busy), 32'd0);
        chk("midrun_counts", 32'(MatchCount) | 32'(ErrCount) | CycleCount, 32'd0);
        Reset = 1'b0; tick();
        run(4'd4, 4, {32'd0,32'd0,32'd0,32'd0,32'd4,32'd3,32'd2,32'd1}, 0, rc);
        chk("restart_pass", 32'(Pass), 32'd1);
        chk("restart_match", 32'(MatchCount), 32'd4);

        // ExpWr during RUN is ignored.
        ExpLen = 4'd1; Start = 1'b1; tick(); Start = 1'b0;
        wait_run();
        ExpWr = 1'b1; ExpAddr = 3'd0; ExpData = 32'hDEAD; tick();
        ExpWr = 1'b0;
        WB_Valid = 1'b1; WB_Data = 32'd1; tick();
        WB_Valid = 1'b0;
        wait_done();
        chk("runwr_pass", 32'(Pass), 32'd1);
        chk("runwr_match", 32'(MatchCount), 32'd1);

        // ExpWr together with Start in IDLE: the run sees the new entry.
        Reset = 1'b1; tick(); Reset = 1'b0; tick();
        ExpWr = 1'b1; ExpAddr = 3'd0; ExpData = 32'h55;
        run(4'd1, 1, {32'd0,32'd0,32'd0,32'd0,32'd0,32'd0,32'd0,32'h55}, 0, rc);
        chk("wrstart_pass", 32'(Pass), 32'd1);
        chk("wrstart_err", 32'(ErrCount), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
